// File: rtl/dino_jump_ctrl.sv
// Per-frame jump physics for the VGA dino: on each VS falling edge it advances
// the vertical position and writes the new Y to peripheral register 1.
module dino_jump_ctrl #(
   parameter int GROUND_Y = 360,
   parameter int JUMP_VEL = 12,
   parameter int GRAVITY  = 1,
   parameter int MAX_FALL = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vga_vs,
   input  logic        jump_req,
   output logic        av_chipselect,
   output logic        av_write,
   output logic [2:0]  av_address,
   output logic [31:0] av_writedata,
   output logic [9:0]  dino_y,
   output logic        airborne,
   output logic [1:0]  o_dbg_seq
);

   // Avalon handshake: the target has no waitrequest, so av_write and
   // av_chipselect are a single-cycle pulse and the write completes in it.
   typedef enum logic [1:0] {
      SEQ_WAIT   = 2'd0,
      SEQ_UPDATE = 2'd1,
      SEQ_WRITE  = 2'd2
   } seq_t;

   typedef enum logic {
      MOT_GROUND = 1'b0,
      MOT_AIR    = 1'b1
   } mot_t;

   localparam logic signed [11:0] GY_S        = 12'(GROUND_Y);
   localparam logic signed [11:0] TAKEOFF_Y   = 12'(GROUND_Y - JUMP_VEL);
   localparam logic signed [5:0]  TAKEOFF_VEL = 6'(JUMP_VEL - GRAVITY);
   localparam logic signed [6:0]  GRAV_S      = 7'(GRAVITY);
   localparam logic signed [6:0]  FALL_LIM    = 7'(-MAX_FALL);
   localparam logic [9:0]         GY_10       = 10'(GROUND_Y);

   seq_t               r_seq;
   mot_t               r_mot;
   logic [9:0]         r_dino_y;
   logic signed [5:0]  r_vel;
   logic               r_jump_pend;
   logic               r_vs_prev;
   logic               r_av_write;
   logic [31:0]        r_av_writedata;
   logic               r_airborne;

   logic               w_tick;
   logic signed [11:0] w_y_ext;
   logic signed [11:0] w_vel_ext;
   logic signed [11:0] w_ny;
   logic signed [6:0]  w_vel_dec;
   logic signed [5:0]  w_vel_nxt;
   logic [9:0]         w_y_nxt;
   logic signed [5:0]  w_vel_fin;
   mot_t               w_mot_nxt;

   assign w_tick = r_vs_prev & ~vga_vs;

   always_comb begin
      w_y_ext   = {2'b00, r_dino_y};
      w_vel_ext = {{6{r_vel[5]}}, r_vel};
      w_vel_dec = $signed({r_vel[5], r_vel}) - GRAV_S;
      w_ny      = GY_S;
      w_vel_nxt = '0;
      if (r_mot == MOT_AIR) begin
         w_ny      = w_y_ext - w_vel_ext;
         w_vel_nxt = (w_vel_dec < FALL_LIM) ? FALL_LIM[5:0] : w_vel_dec[5:0];
      end else if (r_jump_pend) begin
         w_ny      = TAKEOFF_Y;
         w_vel_nxt = TAKEOFF_VEL;
      end
      // Resting on the ground is just a landing that never left the floor.
      if (w_ny >= GY_S) begin
         w_y_nxt   = GY_10;
         w_vel_fin = '0;
         w_mot_nxt = MOT_GROUND;
      end else if (w_ny[11]) begin
         w_y_nxt   = '0;
         w_vel_fin = w_vel_nxt;
         w_mot_nxt = MOT_AIR;
      end else begin
         w_y_nxt   = w_ny[9:0];
         w_vel_fin = w_vel_nxt;
         w_mot_nxt = MOT_AIR;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_seq          <= SEQ_WAIT;
         r_mot          <= MOT_GROUND;
         r_dino_y       <= GY_10;
         r_vel          <= '0;
         r_jump_pend    <= 1'b0;
         r_vs_prev      <= 1'b1;
         r_av_write     <= 1'b0;
         r_av_writedata <= {22'b0, GY_10};
         r_airborne     <= 1'b0;
      end else begin
         r_vs_prev  <= vga_vs;
         r_av_write <= 1'b0;
         if (r_seq != SEQ_UPDATE && jump_req && r_mot == MOT_GROUND)
            r_jump_pend <= 1'b1;
         case (r_seq)
            SEQ_WAIT: begin
               if (w_tick)
                  r_seq <= SEQ_UPDATE;
            end
            SEQ_UPDATE: begin
               r_dino_y       <= w_y_nxt;
               r_vel          <= w_vel_fin;
               r_mot          <= w_mot_nxt;
               r_airborne     <= (w_mot_nxt == MOT_AIR);
               r_jump_pend    <= 1'b0;
               r_av_write     <= 1'b1;
               r_av_writedata <= {22'b0, w_y_nxt};
               r_seq          <= SEQ_WRITE;
            end
            SEQ_WRITE: begin
               r_seq <= SEQ_WAIT;
            end
            default: begin
               r_seq <= SEQ_WAIT;
            end
         endcase
      end
   end

   assign av_write      = r_av_write;
   assign av_chipselect = r_av_write;
   assign av_address    = 3'h1;
   assign av_writedata  = r_av_writedata;
   assign dino_y        = r_dino_y;
   assign airborne      = r_airborne;
   assign o_dbg_seq     = r_seq;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Bench for dino_jump_ctrl: three builds (default, low ground, tall jump) run
// side by side against a per-frame physics model, plus literal jump profiles.
module tb_dino_jump_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic vga_vs = 1'b1;
   logic jump_req = 1'b0;

   always #5 clk = ~clk;

   logic        av_cs[3];
   logic        av_wr[3];
   logic [2:0]  av_addr[3];
   logic [31:0] av_data[3];
   logic [9:0]  dy[3];
   logic        air[3];
   logic [1:0]  dbg[3];

   dino_jump_ctrl u_dut0 (
      .clk(clk), .reset(reset), .vga_vs(vga_vs), .jump_req(jump_req),
      .av_chipselect(av_cs[0]), .av_write(av_wr[0]), .av_address(av_addr[0]),
      .av_writedata(av_data[0]), .dino_y(dy[0]), .airborne(air[0]), .o_dbg_seq(dbg[0])
   );

   dino_jump_ctrl #(.GROUND_Y(20), .JUMP_VEL(31)) u_dut1 (
      .clk(clk), .reset(reset), .vga_vs(vga_vs), .jump_req(jump_req),
      .av_chipselect(av_cs[1]), .av_write(av_wr[1]), .av_address(av_addr[1]),
      .av_writedata(av_data[1]), .dino_y(dy[1]), .airborne(air[1]), .o_dbg_seq(dbg[1])
   );

   dino_jump_ctrl #(.GROUND_Y(600), .JUMP_VEL(31)) u_dut2 (
      .clk(clk), .reset(reset), .vga_vs(vga_vs), .jump_req(jump_req),
      .av_chipselect(av_cs[2]), .av_write(av_wr[2]), .av_address(av_addr[2]),
      .av_writedata(av_data[2]), .dino_y(dy[2]), .airborne(air[2]), .o_dbg_seq(dbg[2])
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [9:0] wr_q0[$];
   logic [9:0] wr_q1[$];
   logic [9:0] wr_q2[$];
   logic [9:0] exp_q[$];

   int m_y[3];
   int m_v[3];
   int m_ph[3];
   int m_data[3];
   bit m_air[3];
   bit m_pend[3];
   bit m_wr[3];
   bit m_vs_prev;

   function automatic int gy_of(input int i);
      case (i)
         1:       return 20;
         2:       return 600;
         default: return 360;
      endcase
   endfunction

   function automatic int jv_of(input int i);
      return (i == 0) ? 12 : 31;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One frame of motion: take-off, ballistic step, then floor/ceiling limits.
   task automatic model_physics(input int i);
      int ny;
      int nv;
      if (m_air[i]) begin
         ny = m_y[i] - m_v[i];
         nv = m_v[i] - 1;
         if (nv < -15) nv = -15;
      end else if (m_pend[i]) begin
         ny = gy_of(i) - jv_of(i);
         nv = jv_of(i) - 1;
      end else begin
         ny = gy_of(i);
         nv = 0;
      end
      if (ny >= gy_of(i)) begin
         m_y[i] = gy_of(i); m_v[i] = 0; m_air[i] = 1'b0;
      end else if (ny < 0) begin
         m_y[i] = 0; m_v[i] = nv; m_air[i] = 1'b1;
      end else begin
         m_y[i] = ny; m_v[i] = nv; m_air[i] = 1'b1;
      end
   endtask

   // m_ph counts cycles since an accepted frame tick: 1 = physics edge, 2 = write cycle.
   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            for (int i = 0; i < 3; i++) begin
               m_y[i] = gy_of(i); m_v[i] = 0; m_air[i] = 1'b0; m_pend[i] = 1'b0;
               m_ph[i] = 0; m_wr[i] = 1'b0; m_data[i] = gy_of(i);
            end
            m_vs_prev = 1'b1;
         end else begin
            for (int i = 0; i < 3; i++) begin
               m_wr[i] = 1'b0;
               if (m_ph[i] == 1) begin
                  model_physics(i);
                  m_pend[i] = 1'b0;
                  m_wr[i] = 1'b1;
                  m_data[i] = m_y[i];
                  m_ph[i] = 2;
               end else begin
                  if (!m_air[i] && jump_req) m_pend[i] = 1'b1;
                  if (m_ph[i] == 2) m_ph[i] = 0;
                  else if (m_vs_prev && !vga_vs) m_ph[i] = 1;
               end
            end
            m_vs_prev = vga_vs;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d av_write", i), 32'(av_wr[i]), 32'(m_wr[i]));
            chk($sformatf("u%0d av_chipselect", i), 32'(av_cs[i]), 32'(m_wr[i]));
            chk($sformatf("u%0d av_address", i), 32'(av_addr[i]), 32'd1);
            chk($sformatf("u%0d av_writedata", i), av_data[i], 32'(m_data[i]));
            chk($sformatf("u%0d dino_y", i), 32'(dy[i]), 32'(m_y[i]));
            chk($sformatf("u%0d airborne", i), 32'(air[i]), 32'(m_air[i]));
            if (av_wr[i] === 1'b1) begin
               case (i)
                  0:       wr_q0.push_back(av_data[i][9:0]);
                  1:       wr_q1.push_back(av_data[i][9:0]);
                  default: wr_q2.push_back(av_data[i][9:0]);
               endcase
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b1; vga_vs = 1'b1; jump_req = 1'b0;
      step(); step();
      reset = 1'b0;
      step();
      wr_q0.delete(); wr_q1.delete(); wr_q2.delete(); exp_q.delete();
   endtask

   task automatic frame(input int lo, input int hi, input bit req_at_tick);
      vga_vs = 1'b0;
      if (req_at_tick) jump_req = 1'b1;
      step();
      if (req_at_tick) jump_req = 1'b0;
      repeat (lo - 1) step();
      vga_vs = 1'b1;
      repeat (hi) step();
   endtask

   task automatic frames(input int n);
      repeat (n) frame(2, 6, 1'b0);
   endtask

   task automatic pulse_jump();
      jump_req = 1'b1;
      step();
      jump_req = 1'b0;
      step();
   endtask

   task automatic cmp_writes(input string name);
      chk({name, " count"}, 32'(wr_q0.size()), 32'(exp_q.size()));
      for (int k = 0; k < wr_q0.size() && k < exp_q.size(); k++)
         chk($sformatf("%s frame %0d", name, k + 1), 32'(wr_q0[k]), 32'(exp_q[k]));
   endtask

   int jump_tab[25] = '{348, 337, 327, 318, 310, 303, 297, 292, 288, 285, 283, 282, 282,
                        283, 285, 288, 292, 297, 303, 310, 318, 327, 337, 348, 360};

   initial begin
      int k;
      int mx;
      int lo;
      int hi;

      // Reset values and idle frames on the ground.
      do_reset();
      chk("t1 reset dino_y", 32'(dy[0]), 32'd360);
      chk("t1 reset writedata", av_data[0], 32'd360);
      chk("t1 reset av_write", 32'(av_wr[0]), 32'd0);
      frames(3);
      exp_q = '{10'd360, 10'd360, 10'd360};
      cmp_writes("t1 ground writes");
      chk("t1 airborne", 32'(air[0]), 32'd0);

      // Single jump pulse: full profile.
      do_reset();
      pulse_jump();
      frames(24);
      chk("t2 airborne frame24", 32'(air[0]), 32'd1);
      frames(1);
      chk("t2 airborne frame25", 32'(air[0]), 32'd0);
      foreach (jump_tab[j]) exp_q.push_back(10'(jump_tab[j]));
      cmp_writes("t2 jump profile");

      // Held request: no mid-air re-trigger, second jump on frame 26.
      do_reset();
      jump_req = 1'b1;
      frames(26);
      jump_req = 1'b0;
      foreach (jump_tab[j]) exp_q.push_back(10'(jump_tab[j]));
      exp_q.push_back(10'd348);
      cmp_writes("t3 held jump");

      // Request only in the tick cycle.
      do_reset();
      frame(2, 6, 1'b1);
      exp_q = '{10'd348};
      cmp_writes("t4 req at tick");

      // Reset during the frame-8 write.
      do_reset();
      pulse_jump();
      frames(7);
      for (int j = 0; j < 7; j++) exp_q.push_back(10'(jump_tab[j]));
      cmp_writes("t5 pre-reset");
      vga_vs = 1'b0;
      k = 0;
      while (av_wr[0] !== 1'b1 && k < 6) begin
         step();
         k++;
      end
      chk("t5 write latency", 32'(k), 32'd2);
      chk("t5 frame8 data", 32'(av_data[0][9:0]), 32'd292);
      reset = 1'b1;
      vga_vs = 1'b1;
      #1;
      chk("t5 async av_write", 32'(av_wr[0]), 32'd0);
      chk("t5 async chipselect", 32'(av_cs[0]), 32'd0);
      chk("t5 async dino_y", 32'(dy[0]), 32'd360);
      step(); step();
      reset = 1'b0;
      step();
      wr_q0.delete(); exp_q.delete();
      frames(1);
      exp_q = '{10'd360};
      cmp_writes("t5 after reset");

      // Ceiling clamp (ground 20) and fall saturation (ground 600).
      do_reset();
      pulse_jump();
      frames(50);
      chk("t6 u1 count", 32'(wr_q1.size()), 32'd50);
      chk("t6 u2 count", 32'(wr_q2.size()), 32'd50);
      if (wr_q1.size() == 50 && wr_q2.size() == 50) begin
         chk("t6 u1 frame1", 32'(wr_q1[0]), 32'd0);
         chk("t6 u1 frame32", 32'(wr_q1[31]), 32'd0);
         chk("t6 u1 frame33", 32'(wr_q1[32]), 32'd1);
         chk("t6 u1 frame37", 32'(wr_q1[36]), 32'd15);
         chk("t6 u1 landing", 32'(wr_q1[37]), 32'd20);
         chk("t6 u1 frame50", 32'(wr_q1[49]), 32'd20);
         chk("t6 u2 peak", 32'(wr_q2[30]), 32'd104);
         chk("t6 u2 frame47", 32'(wr_q2[46]), 32'd224);
         chk("t6 u2 frame48", 32'(wr_q2[47]), 32'd239);
         chk("t6 u2 frame49", 32'(wr_q2[48]), 32'd254);
         mx = 0;
         foreach (wr_q1[j]) if (int'(wr_q1[j]) > mx) mx = int'(wr_q1[j]);
         chk("t6 u1 max y", 32'(mx), 32'd20);
      end

      // Random frames, glitchy VS, random requests and occasional resets.
      do_reset();
      for (int f = 0; f < 250; f++) begin
         lo = $urandom_range(1, 3);
         hi = $urandom_range(1, 10);
         for (int s = 0; s < lo + hi; s++) begin
            vga_vs = (s < lo) ? 1'b0 : 1'b1;
            jump_req = ($urandom_range(0, 5) == 0);
            step();
         end
         if ($urandom_range(0, 59) == 0) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
         end
      end
      jump_req = 1'b0;
      vga_vs = 1'b1;
      repeat (4) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
